// File: rtl/atm_pkg.sv
// Shared op codes, keypad key codes and front-end FSM encoding for the ATM keypad front end.
package atm_pkg;

  localparam logic [2:0] OP_BAL   = 3'd3;
  localparam logic [2:0] OP_WDR   = 3'd4;
  localparam logic [2:0] OP_DEP   = 3'd5;
  localparam logic [2:0] OP_CHPIN = 3'd6;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_CLEAR  = 4'd11;
  localparam logic [3:0] KEY_CANCEL = 4'd12;
  localparam logic [3:0] KEY_LANG   = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_PIN   = 3'd2,
    ST_OP    = 3'd3,
    ST_AMT   = 3'd4,
    ST_NPIN  = 3'd5,
    ST_ISSUE = 3'd6,
    ST_WAIT  = 3'd7
  } fe_state_e;

endpackage

// File: rtl/atm_dec_accum.sv
// Decimal entry field: v = v*10 + d for up to MAXD digits. Priority is clear, then load, then append.
module atm_dec_accum #(
  parameter int W    = 16,
  parameter int MAXD = 4,
  localparam int CW  = $clog2(MAXD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          dig_en_i,
  input  logic [3:0]    digit_i,
  output logic [W-1:0]  val_o,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] MAXC = CW'(MAXD);

  logic [W-1:0]  val_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      val_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      val_q <= W'(digit_i);
      cnt_q <= CW'(1);
    end else if (dig_en_i && (cnt_q < MAXC)) begin
      val_q <= val_q * W'(10) + W'(digit_i);
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign val_o = val_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-to-ATM transaction initiator: builds account/PIN/op/amount/new PIN and runs the req/ack handshake.
// Optional inactivity abort in the entry states is enabled by defining KEYPAD_TIMEOUT_EN.
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = 4,
  parameter int AMT_DIGITS     = 9,
  parameter int ACC_MAX        = 10,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        req_valid,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] newPin,
  output logic [31:0] amount,
  output logic        language,
  input  logic        atm_ack,
  input  logic [31:0] atm_balance,
  input  logic        atm_success,
  output logic        res_valid,
  output logic [31:0] res_balance,
  output logic        res_success,
  output logic [2:0]  fe_state
);

  localparam int PW = $clog2(PIN_DIGITS + 1);
  localparam int AW = $clog2(AMT_DIGITS + 1);

  fe_state_e   state_q;
  logic [2:0]  op_q;
  logic        lang_q, req_q, resv_q, ress_q;
  logic [31:0] resb_q;

  logic [6:0]    acc_val;
  logic [1:0]    acc_cnt;
  logic [PW-1:0] pin_cnt, npin_cnt;
  logic [AW-1:0] amt_cnt;

  logic is_dig, k_ent, k_clr, k_can, k_lang, acc_ok, abort, ack_done, timeout;

  assign is_dig   = key_valid && (key_code <= 4'd9);
  assign k_ent    = key_valid && (key_code == KEY_ENTER);
  assign k_clr    = key_valid && (key_code == KEY_CLEAR);
  assign k_can    = key_valid && (key_code == KEY_CANCEL);
  assign k_lang   = key_valid && (key_code == KEY_LANG);
  assign acc_ok   = (acc_cnt != 2'd0) && (acc_val >= 7'd1) && (acc_val <= 7'(ACC_MAX));
  assign ack_done = (state_q == ST_WAIT) && atm_ack;
  // Once req_valid is up (ISSUE/WAIT) the request is committed until the ATM acks.
  assign abort    = timeout || (k_can && (state_q != ST_WAIT) && (state_q != ST_ISSUE));

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          in_entry;

  assign in_entry = (state_q == ST_ACC) || (state_q == ST_PIN) || (state_q == ST_OP) ||
                    (state_q == ST_AMT) || (state_q == ST_NPIN);
  assign timeout  = in_entry && !key_valid && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              to_cnt_q <= '0;
    else if (key_valid || !in_entry || timeout) to_cnt_q <= '0;
    else                                   to_cnt_q <= to_cnt_q + TW'(1);
  end
`else
  // Counter compiled out: never fires.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  atm_dec_accum #(.W(7), .MAXD(2)) u_acc (
    .clk(clk), .rst(rst),
    .clr_i(abort || ((state_q == ST_ACC) && (k_clr || (k_ent && !acc_ok)))),
    .load_i((state_q == ST_IDLE) && is_dig),
    .dig_en_i((state_q == ST_ACC) && is_dig),
    .digit_i(key_code), .val_o(acc_val), .cnt_o(acc_cnt)
  );

  atm_dec_accum #(.W(16), .MAXD(PIN_DIGITS)) u_pin (
    .clk(clk), .rst(rst),
    .clr_i(abort || ack_done || ((state_q == ST_PIN) && k_clr)),
    .load_i(1'b0),
    .dig_en_i((state_q == ST_PIN) && is_dig),
    .digit_i(key_code), .val_o(pin), .cnt_o(pin_cnt)
  );

  atm_dec_accum #(.W(16), .MAXD(PIN_DIGITS)) u_npin (
    .clk(clk), .rst(rst),
    .clr_i(abort || ack_done || ((state_q == ST_NPIN) && k_clr)),
    .load_i(1'b0),
    .dig_en_i((state_q == ST_NPIN) && is_dig),
    .digit_i(key_code), .val_o(newPin), .cnt_o(npin_cnt)
  );

  atm_dec_accum #(.W(32), .MAXD(AMT_DIGITS)) u_amt (
    .clk(clk), .rst(rst),
    .clr_i(abort || ack_done || ((state_q == ST_AMT) && k_clr)),
    .load_i(1'b0),
    .dig_en_i((state_q == ST_AMT) && is_dig),
    .digit_i(key_code), .val_o(amount), .cnt_o(amt_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      lang_q  <= 1'b0;
      req_q   <= 1'b0;
      resv_q  <= 1'b0;
      resb_q  <= '0;
      ress_q  <= 1'b0;
    end else begin
      resv_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        op_q    <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_dig) begin
              state_q <= ST_ACC;
              op_q    <= '0;
            end else if (k_lang) begin
              lang_q <= ~lang_q;
            end
          end
          ST_ACC:  if (k_ent && acc_ok) state_q <= ST_PIN;
          ST_PIN:  if (k_ent && (pin_cnt == PW'(PIN_DIGITS))) state_q <= ST_OP;
          ST_OP: begin
            if (is_dig && (key_code >= 4'd3) && (key_code <= 4'd6)) op_q <= key_code[2:0];
            else if (k_clr) op_q <= '0;
            else if (k_ent) begin
              case (op_q)
                OP_BAL:         begin state_q <= ST_ISSUE; req_q <= 1'b1; end
                OP_WDR, OP_DEP: state_q <= ST_AMT;
                OP_CHPIN:       state_q <= ST_NPIN;
                default:        ;
              endcase
            end
          end
          ST_AMT: if (k_ent && (amt_cnt != '0)) begin
            state_q <= ST_ISSUE;
            req_q   <= 1'b1;
          end
          ST_NPIN: if (k_ent && (npin_cnt == PW'(PIN_DIGITS))) begin
            state_q <= ST_ISSUE;
            req_q   <= 1'b1;
          end
          ST_ISSUE: state_q <= ST_WAIT;
          ST_WAIT: if (atm_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            resv_q  <= 1'b1;
            resb_q  <= atm_balance;
            ress_q  <= atm_success;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_valid   = req_q;
  assign operation   = op_q;
  assign acc_num     = acc_val[3:0];
  assign language    = lang_q;
  assign res_valid   = resv_q;
  assign res_balance = resb_q;
  assign res_success = ress_q;
  assign fe_state    = state_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench for atm_keypad_frontend: stimulus queues expected requests/responses, a negedge monitor checks them.
module tb_atm_keypad_frontend;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1_000_000;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] np;
    logic [31:0] amt;
  } req_t;

  typedef struct packed {
    logic [31:0] bal;
    logic        sc;
  } res_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        key_valid = 1'b0, atm_ack = 1'b0, atm_success = 1'b0;
  logic [3:0]  key_code = '0;
  logic [31:0] atm_balance = '0;
  logic        req_valid, language, res_valid, res_success;
  logic [2:0]  operation, fe_state;
  logic [3:0]  acc_num;
  logic [15:0] pin, newPin;
  logic [31:0] amount, res_balance;

  int checks = 0, failures = 0;
  req_t rq[$];
  res_t sq[$];

  atm_keypad_frontend #(.PIN_DIGITS(4), .AMT_DIGITS(9), .ACC_MAX(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .req_valid(req_valid), .operation(operation), .acc_num(acc_num), .pin(pin),
    .newPin(newPin), .amount(amount), .language(language), .atm_ack(atm_ack),
    .atm_balance(atm_balance), .atm_success(atm_success), .res_valid(res_valid),
    .res_balance(res_balance), .res_success(res_success), .fe_state(fe_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every request cycle and every response pulse against the scoreboard.
  bit   req_d = 0, res_d = 0, have_cur = 0;
  req_t cur;
  always @(negedge clk) begin
    if (!rst) begin
      req_d = 0; res_d = 0; have_cur = 0;
    end else begin
      if (req_valid && !req_d) begin
        if (rq.size() == 0) chk("unexpected_req", 1, 0);
        else begin cur = rq.pop_front(); have_cur = 1; end
      end
      if (req_valid && have_cur)
        chk("req_fields", {operation, acc_num, pin, newPin, amount}, cur);
      if (!req_valid) have_cur = 0;
      if (res_valid) begin
        if (res_d) chk("res_pulse_width", 2, 1);
        else if (sq.size() == 0) chk("unexpected_res", 1, 0);
        else chk("res_fields", {res_balance, res_success}, sq.pop_front());
      end
      req_d = req_valid;
      res_d = res_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // '0'-'9' digits, E enter, C clear, X cancel, L language; one key per cycle.
  task automatic keyseq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c = s[i];
      case (c)
        "E":     key_code = 4'd10;
        "C":     key_code = 4'd11;
        "X":     key_code = 4'd12;
        "L":     key_code = 4'd13;
        default: key_code = 4'(c - 8'h30);
      endcase
      key_valid = 1'b1;
      cyc(1);
      key_valid = 1'b0;
    end
  endtask

  task automatic do_ack(input logic [31:0] bal, input logic sc, input int dly, input bit with_key);
    int n = 0;
    while (!req_valid && n < 50) begin cyc(1); n++; end
    chk("req_seen", req_valid, 1);
    cyc(dly);
    chk("in_wait", fe_state, 7);
    chk("req_held", req_valid, 1);
    sq.push_back('{bal: bal, sc: sc});
    atm_ack = 1'b1; atm_balance = bal; atm_success = sc;
    if (with_key) begin key_valid = 1'b1; key_code = 4'd7; end
    cyc(1);
    atm_ack = 1'b0; atm_balance = '0; atm_success = 1'b0; key_valid = 1'b0;
    chk("idle_after_ack", fe_state, 0);
    chk("req_drop", req_valid, 0);
    chk("pin_zeroed", pin, 0);
    chk("npin_zeroed", newPin, 0);
    chk("amt_zeroed", amount, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_state", fe_state, 0);
    chk("rst_req", req_valid, 0);
    chk("rst_res", {res_valid, res_balance, res_success}, 0);
    rst = 1'b1;
    cyc(1);
    chk("rst_lang", language, 0);
    keyseq("L");
    chk("lang_toggle", language, 1);
    keyseq("3E1234E4E56");
    chk("amt_state", fe_state, 4);
    chk("amt_partial", amount, 56);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", fe_state, 0);
    chk("async_rst_outs", {req_valid, amount, language}, 0);
    #3 rst = 1'b1;
    cyc(1);

    // Balance enquiry
    rq.push_back('{op: 3, acc: 1, pin: 1234, np: 0, amt: 0});
    keyseq("1E1234E3E");
    do_ack(32'd5000, 1'b1, 1, 0);

    // Deposit with ack withheld 5 cycles
    rq.push_back('{op: 5, acc: 2, pin: 2345, np: 0, amt: 1000});
    keyseq("2E2345E5E1000E");
    do_ack(32'd7000, 1'b1, 5, 0);

    // Boundaries
    keyseq("0E");
    chk("acc0_stays", {fe_state, acc_num}, {3'd1, 4'd0});
    keyseq("11E");
    chk("acc11_stays", {fe_state, acc_num}, {3'd1, 4'd0});
    keyseq("105E");
    chk("acc10_to_pin", {fe_state, acc_num}, {3'd2, 4'd10});
    keyseq("12E");
    chk("short_pin_stays", {fe_state, pin}, {3'd2, 16'd12});
    keyseq("C98765");
    chk("pin_clear_cap", pin, 9876);
    keyseq("E7E");
    chk("op7_ignored", {fe_state, operation}, {3'd3, 3'd0});
    keyseq("4EE");
    chk("amt_empty_enter", fe_state, 4);
    keyseq("1234567890");
    chk("amt_9_digits", amount, 123456789);
    rq.push_back('{op: 4, acc: 10, pin: 9876, np: 0, amt: 123456789});
    keyseq("E");
    do_ack(32'd0, 1'b0, 2, 0);

    // Ack while idle is ignored
    atm_ack = 1'b1; atm_balance = 32'd99; cyc(1); atm_ack = 1'b0; atm_balance = '0;
    chk("ack_idle_ignored", {fe_state, res_valid}, 0);

    // Cancel in NPIN, cancel ignored in WAIT, key dropped with ack
    keyseq("3E1111E6E4321X");
    chk("cancel_npin", {fe_state, req_valid, pin, newPin}, 0);
    rq.push_back('{op: 6, acc: 4, pin: 4444, np: 5555, amt: 0});
    keyseq("4E4444E6E5555E");
    cyc(1);
    keyseq("X");
    chk("cancel_in_wait", {fe_state, req_valid}, {3'd7, 1'b1});
    do_ack(32'd1, 1'b1, 1, 1);

    // Inactivity in PIN
    keyseq("1E");
    cyc(25);
`ifdef KEYPAD_TIMEOUT_EN
    chk("pin_timeout", fe_state, 0);
`else
    chk("pin_no_timeout", fe_state, 2);
    keyseq("X");
`endif

    // Zero PIN and zero amount accepted; long wait without timeout abort
    rq.push_back('{op: 5, acc: 5, pin: 0, np: 0, amt: 0});
    keyseq("5E0000E5E0E");
    do_ack(32'd100, 1'b1, 30, 0);

    cyc(3);
    chk("req_queue_empty", rq.size(), 0);
    chk("res_queue_empty", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
